// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// The state enumeration is shared so the engine and any monitor decode state identically.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   localparam int CLKS_PER_BIT_DEFAULT = 868;
   localparam int DATA_WIDTH_DEFAULT   = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Per-bit baud counter: counts 0..CLKS_PER_BIT-1 while enabled and strobes bit_end on the last count.
// A synchronous clear restarts the bit so a new start bit always gets its full width.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic bit_end
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   logic [CNT_W-1:0] cnt;

   assign bit_end = enable && (cnt == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (reset || clear || bit_end || !enable) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter that pulls characters from a TX FIFO and serialises them LSB first.
// Frames are start, DATA_WIDTH data bits, optional parity, one stop bit.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tx_en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done,
   output uart_tx_state_t        state_dbg
);

   localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

   uart_tx_state_t        state, state_nxt;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] shift_nxt;
   logic [BIT_W-1:0]      bit_cnt;
   logic                  par_q;
   logic                  tx_q, tx_nxt;
   logic                  bit_end;
   logic                  launch;
   logic                  last_data;

   // FIFO handshake: the head word is valid whenever fifo_empty=0; fifo_rd_en
   // pops it in the same cycle and is only ever raised while fifo_empty=0.
   assign launch = tx_en && !fifo_empty && !reset &&
                   ((state == IDLE) || ((state == STOP) && bit_end));

   assign fifo_rd_en = launch;
   assign tx         = tx_q;
   assign busy       = (state != IDLE);
   assign tx_done    = (state == STOP) && bit_end;
   assign state_dbg  = state;
   assign last_data  = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
   assign shift_nxt  = shift_q >> 1;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .reset  (reset),
      .clear  (launch),
      .enable (busy),
      .bit_end(bit_end)
   );

   // tx is registered, so each branch selects the line level for the bit being entered.
   always_comb begin
      state_nxt = state;
      tx_nxt    = tx_q;
      case (state)
         IDLE: begin
            tx_nxt = 1'b1;
            if (launch) begin
               state_nxt = START;
               tx_nxt    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt = DATA;
               tx_nxt    = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (!last_data) begin
                  tx_nxt = shift_nxt[0];
               end else if (PARITY_EN != 0) begin
                  state_nxt = PARITY;
                  tx_nxt    = par_q;
               end else begin
                  state_nxt = STOP;
                  tx_nxt    = 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_nxt = STOP;
               tx_nxt    = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (launch) begin
                  state_nxt = START;
                  tx_nxt    = 1'b0;
               end else begin
                  state_nxt = IDLE;
                  tx_nxt    = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         shift_q <= '0;
         bit_cnt <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state <= state_nxt;
         tx_q  <= tx_nxt;
         if (launch) begin
            shift_q <= fifo_rd_data;
            par_q   <= (^fifo_rd_data) ^ (PARITY_ODD != 0);
            bit_cnt <= '0;
         end else if ((state == DATA) && bit_end) begin
            shift_q <= shift_nxt;
            bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine with CLKS_PER_BIT=4, DATA_WIDTH=8.
// Instance 0 has no parity, instance 1 even parity, instance 2 odd parity.
module tb_uart_tx_engine;
   import uart_pkg::*;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           fifo_empty = 1'b1;
   logic [7:0]     fifo_rd_data = 8'h00;
   logic           en [3];
   logic           rd_w [3];
   logic           tx_w [3];
   logic           busy_w [3];
   logic           done_w [3];
   uart_tx_state_t state_w [3];

   int n_vec = 0;
   int n_err = 0;

   logic           s_tx, s_busy, s_done, s_rd;
   uart_tx_state_t s_state;

   typedef struct {
      logic [7:0]  data;
      int          sel;
      int          nbits;
      logic [11:0] bits;
   } vec_t;

   vec_t vt [7];

   always #5 clk = ~clk;

   uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
      .clk(clk), .reset(reset), .tx_en(en[0]), .fifo_empty(fifo_empty),
      .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_w[0]), .tx(tx_w[0]),
      .busy(busy_w[0]), .tx_done(done_w[0]), .state_dbg(state_w[0])
   );

   uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
      .clk(clk), .reset(reset), .tx_en(en[1]), .fifo_empty(fifo_empty),
      .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_w[1]), .tx(tx_w[1]),
      .busy(busy_w[1]), .tx_done(done_w[1]), .state_dbg(state_w[1])
   );

   uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
      .clk(clk), .reset(reset), .tx_en(en[2]), .fifo_empty(fifo_empty),
      .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_w[2]), .tx(tx_w[2]),
      .busy(busy_w[2]), .tx_done(done_w[2]), .state_dbg(state_w[2])
   );

   task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc %0d: got %0h want %0h", nm, c, act, exp);
      end
   endtask

   task automatic sample(input int sel);
      @(negedge clk);
      s_tx    = tx_w[sel];
      s_busy  = busy_w[sel];
      s_done  = done_w[sel];
      s_rd    = rd_w[sel];
      s_state = state_w[sel];
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pops, nbusy, ndone, len;
      logic [19:0] bb;

      en[0] = 1'b1;
      en[1] = 1'b0;
      en[2] = 1'b0;

      // bits listed LSB first: start bit at index 0, stop bit at index nbits-1
      vt[0] = '{8'hA5, 0, 10, 12'b00_1_10100101_0};
      vt[1] = '{8'h00, 0, 10, 12'b00_1_00000000_0};
      vt[2] = '{8'h3C, 0, 10, 12'b00_1_00111100_0};
      vt[3] = '{8'h07, 1, 11, 12'b0_1_1_00000111_0};
      vt[4] = '{8'h07, 2, 11, 12'b0_1_0_00000111_0};
      vt[5] = '{8'h80, 1, 11, 12'b0_1_1_10000000_0};
      vt[6] = '{8'hFE, 2, 11, 12'b0_1_0_11111110_0};

      // reset: no pop while reset is high even with data waiting
      fifo_empty   = 1'b0;
      fifo_rd_data = 8'h55;
      for (int c = 0; c < 3; c++) begin
         sample(0);
         chk("rst_no_pop", c, s_rd, 1'b0);
         advance();
      end
      reset      = 1'b0;
      fifo_empty = 1'b1;
      en[0]      = 1'b0;
      for (int d = 0; d < 3; d++) begin
         sample(d);
         chk("rst_tx", d, s_tx, 1'b1);
         chk("rst_busy", d, s_busy, 1'b0);
         chk("rst_done", d, s_done, 1'b0);
         chk("rst_state", d, 32'(s_state), 32'(IDLE));
      end
      advance();

      // table-driven single frames
      for (int i = 0; i < 7; i++) begin
         fifo_rd_data  = vt[i].data;
         fifo_empty    = 1'b0;
         en[vt[i].sel] = 1'b1;
         len  = vt[i].nbits * 4;
         pops = 0;
         for (int c = 0; c <= len + 1; c++) begin
            sample(vt[i].sel);
            if (c == 0) begin
               chk("launch_pop", c, s_rd, 1'b1);
               chk("launch_tx", c, s_tx, 1'b1);
               chk("launch_busy", c, s_busy, 1'b0);
            end else if (c <= len) begin
               chk("frame_tx", c, s_tx, vt[i].bits[(c - 1) / 4]);
               chk("frame_busy", c, s_busy, 1'b1);
               chk("frame_done", c, s_done, (c == len) ? 1'b1 : 1'b0);
            end else begin
               chk("post_tx", c, s_tx, 1'b1);
               chk("post_busy", c, s_busy, 1'b0);
            end
            if (s_rd) pops++;
            advance();
            if (s_rd) fifo_empty = 1'b1;
         end
         chk("frame_pops", i, pops, 1);
         en[vt[i].sel] = 1'b0;
         advance();
      end

      // back-to-back 0x00 then 0xFF
      bb           = 20'b1_11111111_0_1_00000000_0;
      fifo_rd_data = 8'h00;
      fifo_empty   = 1'b0;
      en[0]        = 1'b1;
      pops = 0; nbusy = 0; ndone = 0;
      for (int c = 0; c <= 81; c++) begin
         sample(0);
         if (c >= 1 && c <= 80) chk("b2b_tx", c, s_tx, bb[(c - 1) / 4]);
         if (c == 40) chk("b2b_pop2", c, s_rd, 1'b1);
         if (s_rd) pops++;
         if (s_busy) nbusy++;
         if (s_done) ndone++;
         advance();
         if (s_rd) begin
            if (pops == 1) fifo_rd_data = 8'hFF;
            else fifo_empty = 1'b1;
         end
      end
      chk("b2b_pops", 0, pops, 2);
      chk("b2b_busy_cycles", 0, nbusy, 80);
      chk("b2b_done_count", 0, ndone, 2);
      en[0] = 1'b0;
      advance();

      // gating with tx_en
      fifo_rd_data = 8'h5A;
      fifo_empty   = 1'b0;
      for (int c = 0; c < 10; c++) begin
         sample(0);
         chk("gate_no_pop", c, s_rd, 1'b0);
         chk("gate_idle_tx", c, s_tx, 1'b1);
         advance();
      end
      en[0] = 1'b1;
      sample(0);
      chk("gate_pop", 0, s_rd, 1'b1);
      advance();
      pops = 0; ndone = 0;
      for (int c = 1; c <= 60; c++) begin
         sample(0);
         if (c == 1) chk("gate_start_tx", c, s_tx, 1'b0);
         if (c == 40) chk("gate_done", c, s_done, 1'b1);
         if (c == 60) begin
            chk("gate_end_tx", c, s_tx, 1'b1);
            chk("gate_end_busy", c, s_busy, 1'b0);
         end
         if (s_rd) pops++;
         if (s_done) ndone++;
         advance();
         if (c == 10) en[0] = 1'b0;
      end
      chk("gate_extra_pops", 0, pops, 0);
      chk("gate_done_count", 0, ndone, 1);

      // reset during data bit 3, FIFO still non-empty
      fifo_rd_data = 8'hA5;
      fifo_empty   = 1'b0;
      en[0]        = 1'b1;
      pops = 0;
      for (int c = 0; c <= 62; c++) begin
         sample(0);
         if (c == 0) chk("rmid_pop1", c, s_rd, 1'b1);
         if (c == 18) chk("rmid_bit3", c, s_tx, 1'b0);
         if (c == 19) begin
            chk("rmid_tx", c, s_tx, 1'b1);
            chk("rmid_busy", c, s_busy, 1'b0);
            chk("rmid_state", c, 32'(s_state), 32'(IDLE));
            chk("rmid_no_pop", c, s_rd, 1'b0);
         end
         if (c == 20) chk("rmid_pop2", c, s_rd, 1'b1);
         if (c == 21) begin
            chk("rmid_start", c, s_tx, 1'b0);
            chk("rmid_busy2", c, s_busy, 1'b1);
         end
         if (c == 62) begin
            chk("rmid_end_tx", c, s_tx, 1'b1);
            chk("rmid_end_busy", c, s_busy, 1'b0);
         end
         if (s_rd) pops++;
         advance();
         if (c == 17) reset = 1'b1;
         if (c == 19) reset = 1'b0;
         if (c == 20) fifo_empty = 1'b1;
      end
      chk("rmid_pops", 0, pops, 2);

      // empty FIFO with tx_en high
      fifo_empty = 1'b1;
      en[0]      = 1'b1;
      for (int c = 0; c < 100; c++) begin
         sample(0);
         chk("empty_no_pop", c, s_rd, 1'b0);
         chk("empty_tx", c, s_tx, 1'b1);
         chk("empty_busy", c, s_busy, 1'b0);
         advance();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
